// File: rtl/mmio_two_host_arbiter_pkg.sv
// Shared definitions for the two-host MMIO arbiter.
//   - MMIO index/data widths used by mmio_if and the arbiter.
//   - Per-channel arbiter state encoding.
//   - Read data returned to a host whose grant was ended by the watchdog
//     (only used when MMIO_ARBITER_TIMEOUT_EN is defined).
//   - arb_pick(): round-robin choice made while a channel is idle.
package mmio_two_host_arbiter_pkg;

  localparam int TIA_MMIO_INDEX_WIDTH = 16;
  localparam int TIA_MMIO_DATA_WIDTH  = 32;

  typedef enum logic [1:0] {
    ARB_IDLE         = 2'd0,
    ARB_GRANT_FIRST  = 2'd1,
    ARB_GRANT_SECOND = 2'd2
  } arb_state_e;

  localparam logic [TIA_MMIO_DATA_WIDTH-1:0] MMIO_TIMEOUT_READ_DATA = '1;

  // A lone requester always wins; on a tie the host that was not served
  // last wins.
  function automatic arb_state_e arb_pick(input logic req_first,
                                          input logic req_second,
                                          input logic last_second);
    if (req_first && (!req_second || last_second)) return ARB_GRANT_FIRST;
    if (req_second) return ARB_GRANT_SECOND;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/mmio_two_host_arbiter_if.sv
// mmio_if: MMIO read and write channels between one host and one device.
//   host   modport: drives req/index/write_data, receives ack/read_data.
//   device modport: receives req/index/write_data, drives ack/read_data.
// Handshake: req with index (and write_data) held stable until a one-cycle
// ack is sampled.
interface mmio_if
  import mmio_two_host_arbiter_pkg::*;
  ();

  logic                            read_req;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index;
  logic                            read_ack;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data;

  logic                            write_req;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data;
  logic                            write_ack;

  modport host (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_ack, read_data, write_ack
  );

  modport device (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_ack, read_data, write_ack
  );

endinterface

// File: rtl/mmio_two_host_arbiter_channel.sv
// mmio_channel_arbiter: arbitration FSM for one MMIO channel (read or write).
// Grants are registered; a grant is held until the device acks (or, with
// MMIO_ARBITER_TIMEOUT_EN defined, until the watchdog expires).
// Ports:
//   clock, reset       block clock, asynchronous active-low reset
//   req_first_i        request from the first host
//   req_second_i       request from the second host
//   dev_ack_i          device ack for this channel
//   grant_first_o      channel currently owned by the first host
//   grant_second_o     channel currently owned by the second host
//   timeout_o          watchdog ends the current grant this cycle (0 when
//                      the feature is not built)
//   timeout_error_o    sticky watchdog flag (MMIO_ARBITER_TIMEOUT_EN only)
module mmio_channel_arbiter
  import mmio_two_host_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic req_first_i,
  input  logic req_second_i,
  input  logic dev_ack_i,
  output logic grant_first_o,
  output logic grant_second_o,
  output logic timeout_o
`ifdef MMIO_ARBITER_TIMEOUT_EN
  ,
  output logic timeout_error_o
`endif
);

  arb_state_e state_q;
  arb_state_e pick_d;
  logic       last_second_q;
  logic       grant_first_q;
  logic       grant_second_q;
  logic       done;

  assign pick_d = arb_pick(req_first_i, req_second_i, last_second_q);
  assign done   = dev_ack_i | timeout_o;

  // Reset leaves last_second_q set so the first host wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ARB_IDLE;
      last_second_q  <= 1'b1;
      grant_first_q  <= 1'b0;
      grant_second_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          state_q        <= pick_d;
          grant_first_q  <= (pick_d == ARB_GRANT_FIRST);
          grant_second_q <= (pick_d == ARB_GRANT_SECOND);
        end
        ARB_GRANT_FIRST: begin
          if (done) begin
            state_q       <= ARB_IDLE;
            grant_first_q <= 1'b0;
            last_second_q <= 1'b0;
          end
        end
        ARB_GRANT_SECOND: begin
          if (done) begin
            state_q        <= ARB_IDLE;
            grant_second_q <= 1'b0;
            last_second_q  <= 1'b1;
          end
        end
        default: begin
          state_q        <= ARB_IDLE;
          grant_first_q  <= 1'b0;
          grant_second_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_first_o  = grant_first_q;
  assign grant_second_o = grant_second_q;

`ifdef MMIO_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_error_q;

  // cnt_q counts completed grant cycles without an ack; the grant is
  // abandoned in the cycle after TIMEOUT_CYCLES such cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q           <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      if ((state_q == ARB_IDLE) || done) cnt_q <= '0;
      else                               cnt_q <= cnt_q + CNT_W'(1);
      if (timeout_o) timeout_error_q <= 1'b1;
    end
  end

  assign timeout_o       = (state_q != ARB_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_error_o = timeout_error_q;
`else
  // Without the watchdog the limit has no effect; fold it into a sink.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: rtl/mmio_two_host_arbiter.sv
// mmio_two_host_arbiter: shares one MMIO device port between two hosts.
// Read and write channels are arbitrated independently (one
// mmio_channel_arbiter each); this level only muxes the interfaces.
// Optional feature: define MMIO_ARBITER_TIMEOUT_EN to add a device-ack
// watchdog of TIMEOUT_CYCLES cycles and the timeout_error port.
// Ports:
//   clock                  block clock
//   reset                  asynchronous active-low reset
//   first_host_interface   mmio_if.device, first host (wins the first tie)
//   second_host_interface  mmio_if.device, second host
//   device_interface       mmio_if.host, shared downstream device
//   timeout_error          sticky watchdog flag (MMIO_ARBITER_TIMEOUT_EN only)
module mmio_two_host_arbiter
  import mmio_two_host_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic   clock,
  input  logic   reset,
  mmio_if.device first_host_interface,
  mmio_if.device second_host_interface,
  mmio_if.host   device_interface
`ifdef MMIO_ARBITER_TIMEOUT_EN
  ,
  output logic   timeout_error
`endif
);

  logic rd_grant_first, rd_grant_second, rd_timeout;
  logic wr_grant_first, wr_grant_second, wr_timeout;
`ifdef MMIO_ARBITER_TIMEOUT_EN
  logic rd_timeout_error, wr_timeout_error;
`endif

  mmio_channel_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_read_arb (
    .clock          (clock),
    .reset          (reset),
    .req_first_i    (first_host_interface.read_req),
    .req_second_i   (second_host_interface.read_req),
    .dev_ack_i      (device_interface.read_ack),
    .grant_first_o  (rd_grant_first),
    .grant_second_o (rd_grant_second),
    .timeout_o      (rd_timeout)
`ifdef MMIO_ARBITER_TIMEOUT_EN
    ,
    .timeout_error_o(rd_timeout_error)
`endif
  );

  mmio_channel_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_write_arb (
    .clock          (clock),
    .reset          (reset),
    .req_first_i    (first_host_interface.write_req),
    .req_second_i   (second_host_interface.write_req),
    .dev_ack_i      (device_interface.write_ack),
    .grant_first_o  (wr_grant_first),
    .grant_second_o (wr_grant_second),
    .timeout_o      (wr_timeout)
`ifdef MMIO_ARBITER_TIMEOUT_EN
    ,
    .timeout_error_o(wr_timeout_error)
`endif
  );

`ifdef MMIO_ARBITER_TIMEOUT_EN
  assign timeout_error = rd_timeout_error | wr_timeout_error;
`endif

  // Device side: forward the owning host, all zero while idle. The
  // request is withdrawn in the cycle the watchdog ends a grant.
  always_comb begin
    device_interface.read_req   = 1'b0;
    device_interface.read_index = '0;
    if (rd_grant_first) begin
      device_interface.read_req   = first_host_interface.read_req & ~rd_timeout;
      device_interface.read_index = first_host_interface.read_index;
    end else if (rd_grant_second) begin
      device_interface.read_req   = second_host_interface.read_req & ~rd_timeout;
      device_interface.read_index = second_host_interface.read_index;
    end
  end

  always_comb begin
    device_interface.write_req   = 1'b0;
    device_interface.write_index = '0;
    device_interface.write_data  = '0;
    if (wr_grant_first) begin
      device_interface.write_req   = first_host_interface.write_req & ~wr_timeout;
      device_interface.write_index = first_host_interface.write_index;
      device_interface.write_data  = first_host_interface.write_data;
    end else if (wr_grant_second) begin
      device_interface.write_req   = second_host_interface.write_req & ~wr_timeout;
      device_interface.write_index = second_host_interface.write_index;
      device_interface.write_data  = second_host_interface.write_data;
    end
  end

  // Host side: ack and read data reach only the owner of the channel.
  assign first_host_interface.read_ack   = rd_grant_first  & (device_interface.read_ack | rd_timeout);
  assign second_host_interface.read_ack  = rd_grant_second & (device_interface.read_ack | rd_timeout);
  assign first_host_interface.write_ack  = wr_grant_first  & (device_interface.write_ack | wr_timeout);
  assign second_host_interface.write_ack = wr_grant_second & (device_interface.write_ack | wr_timeout);

  assign first_host_interface.read_data  = !rd_grant_first  ? '0 :
                                           rd_timeout ? MMIO_TIMEOUT_READ_DATA :
                                           device_interface.read_data;
  assign second_host_interface.read_data = !rd_grant_second ? '0 :
                                           rd_timeout ? MMIO_TIMEOUT_READ_DATA :
                                           device_interface.read_data;

endmodule
